// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle controller.
//   state_t  - controller states
//   cls_t    - state class seen by the ALU op decoder
//   OP_*/FN_* opcode and funct values, ALU_* select codes, SRCB_* b-mux codes
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;
    typedef enum logic [2:0] {C_NONE, C_PC4, C_DEC, C_R, C_I, C_ADDR, C_BR, C_J} cls_t;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_BEQ = 3'b101;
    localparam logic [2:0] ALU_J   = 3'b110;
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_SIMM = 2'b10;
    localparam logic [1:0] SRCB_ZIMM = 2'b11;

    function automatic cls_t state_cls(input state_t s);
        case (s)
            S_FETCH:    return C_PC4;
            S_DECODE:   return C_DEC;
            S_EXEC_R:   return C_R;
            S_EXEC_I:   return C_I;
            S_MEM_ADDR: return C_ADDR;
            S_BRANCH:   return C_BR;
            S_JUMP:     return C_J;
            default:    return C_NONE;
        endcase
    endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps {state class, opcode, funct} to ALU select, b-mux select and illegal flag.
//   i_cls        - class of the current controller state
//   i_opcode     - opcode (live in DECODE, latched afterwards)
//   i_funct      - latched funct
//   o_alu_select - ALU operation code
//   o_alu_src_b  - ALU b operand select
//   o_illegal    - unknown opcode (decode class) or unknown funct (R class)
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  cls_t        i_cls,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_select,
    output logic [1:0]  o_alu_src_b,
    output logic        o_illegal
);
    always_comb begin
        o_alu_select = ALU_AND;
        o_alu_src_b  = SRCB_RT;
        o_illegal    = 1'b0;
        case (i_cls)
            C_PC4: begin
                o_alu_select = ALU_ADD;
                o_alu_src_b  = SRCB_4;
            end
            C_DEC: o_illegal = !(i_opcode inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI,
                                                  OP_ORI, OP_XORI, OP_BEQ, OP_J});
            C_R: begin
                case (i_funct)
                    FN_ADD:  o_alu_select = ALU_ADD;
                    FN_SUB:  o_alu_select = ALU_SUB;
                    FN_AND:  o_alu_select = ALU_AND;
                    FN_OR:   o_alu_select = ALU_OR;
                    FN_XOR:  o_alu_select = ALU_XOR;
                    default: o_illegal = 1'b1;
                endcase
            end
            // addi sign-extends; the logical immediates zero-extend
            C_I: begin
                o_alu_src_b  = (i_opcode == OP_ADDI) ? SRCB_SIMM : SRCB_ZIMM;
                o_alu_select = (i_opcode == OP_ANDI) ? ALU_AND :
                               (i_opcode == OP_ORI)  ? ALU_OR  :
                               (i_opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            C_ADDR: begin
                o_alu_select = ALU_ADD;
                o_alu_src_b  = SRCB_SIMM;
            end
            C_BR: o_alu_select = ALU_BEQ;
            C_J:  o_alu_select = ALU_J;
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main controller sequencing fetch/decode/execute/memory/writeback.
//   clk, rst_n        - clock, async active-low reset
//   opcode, funct     - IR fields
//   mem_ready         - memory completes current access
//   pc_en, ir_en      - PC / IR load
//   mem_rd, mem_wr    - memory requests; iord selects the address source
//   reg_wr, reg_dst, mem_to_reg - register file write controls
//   alu_src_a, alu_src_b, alu_select - ALU operand and operation selects
//   ctrl_err          - sticky illegal-instruction / memory-timeout flag
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ir_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iord,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_select,
    output logic        ctrl_err
);
    state_t      r_state;
    state_t      w_next;
    cls_t        w_cls;
    logic [3:0]  r_wait;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    logic        r_err;
    logic [5:0]  w_op;
    logic        w_mem;
    logic        w_tmo;
    logic        w_illegal;

    assign w_mem = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    // The count is registered, so the timeout cycle itself is a Moore condition
    assign w_tmo = w_mem && (r_wait == 4'(MEM_WAIT_MAX));
    // Dispatch needs the opcode during DECODE, before it has been latched
    assign w_op  = (r_state == S_DECODE) ? opcode : r_op;
    assign w_cls = state_cls(r_state);
    assign ctrl_err = r_err;

    alu_op_decoder u_alu_op_decoder (
        .i_cls        (w_cls),
        .i_opcode     (w_op),
        .i_funct      (r_funct),
        .o_alu_select (alu_select),
        .o_alu_src_b  (alu_src_b),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait  <= 4'd0;
            r_op    <= 6'd0;
            r_funct <= 6'd0;
            r_err   <= 1'b0;
        end else begin
            // Any state change (or a timeout re-entering FETCH) restarts the count
            r_wait <= (w_next != r_state || w_tmo) ? 4'd0 : r_wait + {3'd0, w_mem && !mem_ready};
            r_err  <= r_err | w_illegal | w_tmo;
            if (r_state == S_DECODE) begin
                r_op    <= opcode;
                r_funct <= funct;
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = (mem_ready && !w_tmo) ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = w_illegal                              ? S_FETCH    :
                                 (opcode == OP_R)                       ? S_EXEC_R   :
                                 (opcode == OP_LW || opcode == OP_SW)   ? S_MEM_ADDR :
                                 (opcode == OP_BEQ)                     ? S_BRANCH   :
                                 (opcode == OP_J)                       ? S_JUMP     : S_EXEC_I;
            S_EXEC_R:   w_next = w_illegal ? S_FETCH : S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = w_tmo ? S_FETCH : mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_next = (w_tmo || mem_ready) ? S_FETCH : S_MEM_WR;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_rd = !w_tmo;
                ir_en  = mem_ready && !w_tmo;
                pc_en  = mem_ready && !w_tmo;
            end
            S_EXEC_R, S_EXEC_I, S_MEM_ADDR: alu_src_a = 1'b1;
            S_WB_R: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            S_WB_I: reg_wr = 1'b1;
            S_MEM_RD: begin
                mem_rd = !w_tmo;
                iord   = 1'b1;
            end
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr = !w_tmo;
                iord   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_en     = 1'b1;
            end
            S_JUMP: pc_en = 1'b1;
            default: ;
        endcase
    end
endmodule
